// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction ROM address/data, redirect/halt control and the
// valid/ready instruction handshake toward decode.
interface fetch_ctrl_if #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [AW-1:0] imem_pc;
    logic [DW-1:0] imem_inst;
    logic          halt;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          if_valid;
    logic [DW-1:0] if_inst;
    logic [AW-1:0] if_pc;
    logic          id_ready;
    logic [CW-1:0] buf_count;

    modport master (
        output imem_pc,
        input  imem_inst,
        input  halt,
        input  redirect_valid,
        input  redirect_pc,
        output if_valid,
        output if_inst,
        output if_pc,
        input  id_ready,
        output buf_count
    );

    modport slave (
        input  imem_pc,
        output imem_inst,
        output halt,
        output redirect_valid,
        output redirect_pc,
        input  if_valid,
        input  if_inst,
        input  if_pc,
        output id_ready,
        input  buf_count
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, reads the combinational ROM and queues
// {pc, inst} pairs in a small FIFO presented to decode over valid/ready.
module fetch_ctrl #(
    parameter int AW    = 10,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst,
    fetch_ctrl_if.master   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_q,     pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [DW-1:0] inst_q [DEPTH];
    logic [AW-1:0] epc_q  [DEPTH];

    logic if_valid_w;
    logic pop_w;
    logic push_w;

    // A redirect masks the head so decode cannot accept an entry being flushed.
    always_comb begin
        if_valid_w = (count_q != '0) && !bus.redirect_valid;
        pop_w      = if_valid_w && bus.id_ready;
        push_w     = !bus.redirect_valid && !bus.halt &&
                     ((count_q < CW'(DEPTH)) || pop_w);
    end

    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            pc_d     = bus.redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_w) begin
                pc_d     = pc_q + AW'(1);
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_w) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_w && !pop_w) begin
                count_d = count_q + CW'(1);
            end else if (pop_w && !push_w) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_q[i] <= '0;
                epc_q[i]  <= '0;
            end
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_w) begin
                inst_q[wr_ptr_q] <= bus.imem_inst;
                epc_q[wr_ptr_q]  <= pc_q;
            end
        end
    end

    // Head fields are driven even when invalid so decode sees stable values.
    assign bus.imem_pc   = pc_q;
    assign bus.if_valid  = if_valid_w;
    assign bus.if_inst   = inst_q[rd_ptr_q];
    assign bus.if_pc     = epc_q[rd_ptr_q];
    assign bus.buf_count = count_q;

endmodule
